// File: rtl/uarttx_port_pkg.sv
// uarttx_port_pkg
// Shared definitions for the Game Boy bus UART transmitter:
//   - register offsets relative to BASE_ADDR (DATA, STATUS)
//   - STATUS register bit positions
//   - shift engine state encoding
//   - even parity helper
// Optional feature macro: UARTTX_PARITY_EN adds a PARITY state (8E1 frames).
package uarttx_port_pkg;

    localparam logic [15:0] REG_DATA   = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_INTEN = 7;

`ifdef UARTTX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    function automatic logic even_parity(input logic [7:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uarttx_port_if.sv
// uarttx_port_if
// CPU bus bundle for memory-mapped peripherals.
//   address [15:0]  CPU bus address
//   indata  [7:0]   CPU write data
//   outdata [7:0]   peripheral read data, 8'h00 when not selected
//   load            CPU read strobe
//   store           CPU write strobe, one clockgb cycle per access
// master: the CPU side; slave: the peripheral side.
interface uarttx_port_if;
    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;

    modport master (output address, output indata, output load, output store,
                    input outdata);
    modport slave  (input address, input indata, input load, input store,
                    output outdata);
endinterface

// File: rtl/uarttx_shift.sv
// uarttx_shift
// Serialising engine: bit-period divider, shift register and frame FSM.
// Ports:
//   clockgb      system clock
//   resetn       async active-low reset
//   data [7:0]   byte offered by the FIFO
//   valid        data holds a byte
//   ready        engine is IDLE; valid && ready pops the byte
//   done         high for the last cycle of the stop bit
//   UART_TX      registered serial line, idle high
// Optional feature macro: UARTTX_PARITY_EN inserts an even parity bit.
module uarttx_shift
    import uarttx_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 9
)(
    input  logic       clockgb,
    input  logic       resetn,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       done,
    output logic       UART_TX
);

    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_next;
    logic [DIV_W-1:0] divider, divider_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             tx_next;
    logic             bit_tick;
`ifdef UARTTX_PARITY_EN
    logic             parity, parity_next;
`endif

    assign bit_tick = (divider == DIV_LAST);

    // The line level is computed for the state being entered, so UART_TX
    // changes on the same edge as the state and comes straight from a flop.
    always_comb begin
        state_next   = state;
        divider_next = divider + DIV_W'(1);
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = UART_TX;
        done         = 1'b0;
        ready        = (state == ST_IDLE);
`ifdef UARTTX_PARITY_EN
        parity_next  = parity;
`endif
        unique case (state)
            ST_IDLE: begin
                divider_next = '0;
                tx_next      = 1'b1;
                if (valid) begin
                    shift_next   = data;
                    bit_idx_next = 3'd0;
                    tx_next      = 1'b0;
                    state_next   = ST_START;
`ifdef UARTTX_PARITY_EN
                    parity_next  = even_parity(data);
`endif
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    divider_next = '0;
                    tx_next      = shift[0];
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    divider_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UARTTX_PARITY_EN
                        tx_next    = parity;
                        state_next = ST_PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
`endif
                    end else begin
                        // shift[1] becomes shift[0] after this edge
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift[1];
                    end
                end
            end
`ifdef UARTTX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    divider_next = '0;
                    tx_next      = 1'b1;
                    state_next   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    divider_next = '0;
                    tx_next      = 1'b1;
                    done         = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: begin
                divider_next = '0;
                tx_next      = 1'b1;
                state_next   = ST_IDLE;
            end
        endcase
    end

    // Engine state register; reset forces the line high immediately.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            divider <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            UART_TX <= 1'b1;
`ifdef UARTTX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            divider <= divider_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            UART_TX <= tx_next;
`ifdef UARTTX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

endmodule

// File: rtl/uarttx_port.sv
// uarttx_port
// Memory-mapped UART transmitter on the Game Boy bus. The CPU pushes bytes
// into a small TX FIFO through DATA; uarttx_shift drains it onto UART_TX.
// Registers:
//   BASE_ADDR+0  DATA    write pushes a byte, read returns 8'hff
//   BASE_ADDR+1  STATUS  {int_en, 3'b0, ovf, empty, full, busy}
//                        write: bit7 -> int_en, bit3=1 clears ovf
// Ports:
//   clockgb   system clock
//   resetn    async active-low reset
//   bus       uarttx_port_if.slave (address, indata, outdata, load, store)
//   tx_int    one-cycle pulse when a frame ends with the FIFO empty (int_en=1)
//   UART_TX   serial line, idle high
// Optional feature macro: UARTTX_PARITY_EN selects 8E1 frames instead of 8N1.
module uarttx_port
    import uarttx_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hff70,
    parameter int          CLKS_PER_BIT = 9,
    parameter int          FIFO_DEPTH   = 4
)(
    input  logic            clockgb,
    input  logic            resetn,
    uarttx_port_if.slave    bus,
    output logic            tx_int,
    output logic            UART_TX
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_empty, fifo_full;
    logic             sel_data, sel_status;
    logic             push_req, push, pop, stat_write;
    logic             eng_ready, eng_done;
    logic             int_en, ovf;
    logic [7:0]       status;

    assign sel_data   = (bus.address == BASE_ADDR + REG_DATA);
    assign sel_status = (bus.address == BASE_ADDR + REG_STATUS);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);

    // A push into a full FIFO still lands when the engine pops in the same
    // cycle, because the pop frees the slot the push writes.
    assign pop        = eng_ready && !fifo_empty;
    assign push_req   = bus.store && sel_data;
    assign push       = push_req && (!fifo_full || pop);
    assign stat_write = bus.store && sel_status;

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clockgb) begin
        if (push) fifo_mem[wr_ptr] <= bus.indata;
    end

    // Control/status flags and the completion interrupt.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            int_en <= 1'b0;
            ovf    <= 1'b0;
            tx_int <= 1'b0;
        end else begin
            tx_int <= eng_done && fifo_empty && int_en;
            if (push_req && fifo_full && !pop)
                ovf <= 1'b1;
            else if (stat_write && bus.indata[STAT_OVF])
                ovf <= 1'b0;
            if (stat_write)
                int_en <= bus.indata[STAT_INTEN];
        end
    end

    always_comb begin
        status             = 8'h00;
        status[STAT_INTEN] = int_en;
        status[STAT_OVF]   = ovf;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = !eng_ready;
    end

    // Read data is OR-combined on the bus, so drive zero unless selected.
    always_comb begin
        bus.outdata = 8'h00;
        if (bus.load) begin
            if (sel_data)
                bus.outdata = 8'hff;
            else if (sel_status)
                bus.outdata = status;
        end
    end

    uarttx_shift #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_shift (
        .clockgb (clockgb),
        .resetn  (resetn),
        .data    (fifo_mem[rd_ptr]),
        .valid   (!fifo_empty),
        .ready   (eng_ready),
        .done    (eng_done),
        .UART_TX (UART_TX)
    );

endmodule

// File: tb/tb_uarttx_port.sv
// tb_uarttx_port
// Directed bench for uarttx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Bytes written to DATA are queued as expected frames; each frame seen on
// UART_TX pops the queue and is compared level by level, cycle by cycle.
// Honours UARTTX_PARITY_EN (8E1 frames) when defined.
module tb_uarttx_port;

    localparam int CPB = 4;
`ifdef UARTTX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [15:0] DATA_ADDR   = 16'hff70;
    localparam logic [15:0] STATUS_ADDR = 16'hff71;
    localparam int MAX_WAIT = 200;

    logic clockgb = 1'b0;
    logic resetn;
    logic tx_int;
    logic UART_TX;

    int assertCount = 0;
    int failCount   = 0;
    logic [7:0] expQ [$];

    uarttx_port_if bus();

    uarttx_port #(
        .BASE_ADDR    (16'hff70),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clockgb (clockgb),
        .resetn  (resetn),
        .bus     (bus),
        .tx_int  (tx_int),
        .UART_TX (UART_TX)
    );

    always #5 clockgb = ~clockgb;

    task automatic checkValue(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One-cycle bus write, started at a negedge (or just after one).
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] value);
        bus.address = addr;
        bus.indata  = value;
        bus.store   = 1'b1;
        @(negedge clockgb);
        bus.store   = 1'b0;
    endtask

    task automatic writeData(input logic [7:0] value);
        expQ.push_back(value);
        applyStimulus(DATA_ADDR, value);
    endtask

    task automatic readBus(input logic [15:0] addr, input logic [7:0] expected,
                           input string tag);
        bus.address = addr;
        bus.load    = 1'b1;
        #1;
        checkValue(tag, 16'(bus.outdata), 16'(expected));
        bus.load    = 1'b0;
    endtask

    // Waits for the start bit, checks its arrival against expWait negedges,
    // then checks every cycle of the frame against the oldest queued byte.
    // With withBusy set, the caller holds a STATUS read on the bus.
    task automatic checkOutput(input int expWait, input bit withBusy, input string tag);
        int waited;
        logic [7:0] b;
        logic [FRAME_BITS-1:0] frame;
        waited = 0;
        do begin
            @(negedge clockgb);
            waited++;
        end while (UART_TX !== 1'b0 && waited < MAX_WAIT);
        checkValue({tag, " start latency"}, 16'(waited), 16'(expWait));
        if (UART_TX !== 1'b0) return;
        if (expQ.size() == 0) begin
            checkValue({tag, " queue empty"}, 16'(expQ.size()), 16'd1);
            return;
        end
        b = expQ.pop_front();
`ifdef UARTTX_PARITY_EN
        frame = {1'b1, ^b, b, 1'b0};
`else
        frame = {1'b1, b, 1'b0};
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (i != 0 || c != 0) @(negedge clockgb);
                checkValue($sformatf("%s bit%0d cyc%0d line", tag, i, c),
                           16'(UART_TX), 16'(frame[i]));
                checkValue($sformatf("%s bit%0d cyc%0d tx_int", tag, i, c),
                           16'(tx_int), 16'd0);
                if (withBusy)
                    checkValue($sformatf("%s bit%0d cyc%0d busy", tag, i, c),
                               16'(bus.outdata[0]), 16'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lowCount;
        bus.address = 16'h0000;
        bus.indata  = 8'h00;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        resetn      = 1'b0;
        repeat (3) @(negedge clockgb);
        resetn = 1'b1;
        @(negedge clockgb);

        // Reset state and register decode
        checkValue("reset UART_TX", 16'(UART_TX), 16'd1);
        checkValue("reset tx_int", 16'(tx_int), 16'd0);
        readBus(STATUS_ADDR, 8'h04, "reset STATUS");
        readBus(DATA_ADDR, 8'hff, "DATA read");
        readBus(16'hff72, 8'h00, "unmapped read");
        bus.address = STATUS_ADDR;
        #1;
        checkValue("no load no data", 16'(bus.outdata), 16'd0);

        // Single frame with exact latency and busy throughout
        writeData(8'ha5);
        bus.address = STATUS_ADDR;
        bus.load    = 1'b1;
        checkOutput(1, 1'b1, "frame a5");
        @(negedge clockgb);
        checkValue("busy after a5", 16'(bus.outdata[0]), 16'd0);
        checkValue("no int when disabled", 16'(tx_int), 16'd0);
        bus.load = 1'b0;

        // Completion interrupt
        applyStimulus(STATUS_ADDR, 8'h80);
        readBus(STATUS_ADDR, 8'h84, "int_en set");
        writeData(8'h00);
        checkOutput(1, 1'b0, "frame 00");
        @(negedge clockgb);
        checkValue("tx_int pulse", 16'(tx_int), 16'd1);
        @(negedge clockgb);
        checkValue("tx_int one cycle", 16'(tx_int), 16'd0);
        applyStimulus(STATUS_ADDR, 8'h00);
        readBus(STATUS_ADDR, 8'h04, "int_en cleared");

        // Burst of six writes: 01 starts, 02..05 fill the FIFO, 06 overflows
        fork
            begin
                for (int i = 1; i <= 5; i++) writeData(8'(i));
                applyStimulus(DATA_ADDR, 8'h06);
                readBus(STATUS_ADDR, 8'h0b, "overflow status");
                applyStimulus(STATUS_ADDR, 8'h08);
                readBus(STATUS_ADDR, 8'h03, "ovf cleared");
            end
            checkOutput(2, 1'b0, "frame 01");
        join

        // Push into a full FIFO on the cycle the engine pops: accepted, no ovf
        fork
            begin
                @(negedge clockgb);
                writeData(8'h77);
                readBus(STATUS_ADDR, 8'h03, "push with pop");
            end
            checkOutput(2, 1'b0, "frame 02");
        join
        checkOutput(2, 1'b0, "frame 03");
        checkOutput(2, 1'b0, "frame 04");
        checkOutput(2, 1'b0, "frame 05");
        checkOutput(2, 1'b0, "frame 77");
        @(negedge clockgb);
        checkValue("no int after drain", 16'(tx_int), 16'd0);
        readBus(STATUS_ADDR, 8'h04, "drained STATUS");
        checkValue("scoreboard drained", 16'(expQ.size()), 16'd0);

        // Reset during data bit 3 of 8'h35 with 8'h5a still queued
        writeData(8'h35);
        writeData(8'h5a);
        repeat (17) @(negedge clockgb);
        checkValue("bit3 level", 16'(UART_TX), 16'd0);
        resetn = 1'b0;
        #1;
        checkValue("reset line high", 16'(UART_TX), 16'd1);
        expQ.delete();
        repeat (2) @(negedge clockgb);
        resetn = 1'b1;
        @(negedge clockgb);
        readBus(STATUS_ADDR, 8'h04, "STATUS after reset");
        lowCount = 0;
        repeat (60) begin
            @(negedge clockgb);
            if (UART_TX !== 1'b1) lowCount++;
        end
        checkValue("quiet after reset", 16'(lowCount), 16'd0);

`ifdef UARTTX_PARITY_EN
        // 8E1 frame: parity of 8'h07 is 1, 44 cycles long
        writeData(8'h07);
        checkOutput(1, 1'b0, "parity frame");
        @(negedge clockgb);
        readBus(STATUS_ADDR, 8'h04, "parity frame end");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
